// File: rtl/mem_load_controller.sv
// Boot-time loader: streams the first N words into IM and the next M words into DM
// through registered *_load ports, holding the core in reset until loading completes.
module mem_load_controller #(
    parameter int ADDRESS_WIDTH = 11,
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [ADDRESS_WIDTH:0]   im_count,
    input  logic [ADDRESS_WIDTH:0]   dm_count,
    input  logic                     in_valid,
    input  logic [DATA_WIDTH-1:0]    in_data,
    output logic                     in_ready,
    output logic                     loading,
    output logic                     cpu_rst_n,
    output logic                     busy,
    output logic                     done,
    output logic                     im_cen_load,
    output logic                     im_wen_load,
    output logic                     im_oen_load,
    output logic [ADDRESS_WIDTH-1:0] im_addr_load,
    output logic [DATA_WIDTH-1:0]    im_datain_load,
    output logic                     dm_cen_load,
    output logic                     dm_wen_load,
    output logic                     dm_oen_load,
    output logic [ADDRESS_WIDTH-1:0] dm_addr_load,
    output logic [DATA_WIDTH-1:0]    dm_datain_load
);

    localparam int CW = ADDRESS_WIDTH + 1;
    localparam logic [CW-1:0] MAX_WORDS = {1'b1, {ADDRESS_WIDTH{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_IM,
        S_LOAD_DM,
        S_FLUSH,
        S_RUN
    } state_e;

    state_e                   state_q, state_d;
    logic [CW-1:0]            im_rem_q, im_rem_d;
    logic [CW-1:0]            dm_rem_q, dm_rem_d;
    logic [ADDRESS_WIDTH-1:0] im_ptr_q, im_ptr_d;
    logic [ADDRESS_WIDTH-1:0] dm_ptr_q, dm_ptr_d;
    logic                     im_wr_q, im_wr_d;
    logic                     dm_wr_q, dm_wr_d;
    logic [ADDRESS_WIDTH-1:0] im_addr_q, im_addr_d;
    logic [ADDRESS_WIDTH-1:0] dm_addr_q, dm_addr_d;
    logic [DATA_WIDTH-1:0]    im_data_q, im_data_d;
    logic [DATA_WIDTH-1:0]    dm_data_q, dm_data_d;

    logic [CW-1:0] im_clamped;
    logic [CW-1:0] dm_clamped;
    logic          accept;

    // Counts above the memory depth would otherwise wrap the write address.
    assign im_clamped = (im_count > MAX_WORDS) ? MAX_WORDS : im_count;
    assign dm_clamped = (dm_count > MAX_WORDS) ? MAX_WORDS : dm_count;

    // NOTE: every signal gets its default first so no path leaves one unassigned (no latches).
    always_comb begin
        state_d   = state_q;
        im_rem_d  = im_rem_q;
        dm_rem_d  = dm_rem_q;
        im_ptr_d  = im_ptr_q;
        dm_ptr_d  = dm_ptr_q;
        im_wr_d   = 1'b0;
        dm_wr_d   = 1'b0;
        im_addr_d = im_addr_q;
        dm_addr_d = dm_addr_q;
        im_data_d = im_data_q;
        dm_data_d = dm_data_q;
        in_ready  = (state_q == S_LOAD_IM) || (state_q == S_LOAD_DM);
        accept    = in_valid && in_ready;

        unique case (state_q)
            S_IDLE, S_RUN: begin
                if (start) begin
                    im_rem_d = im_clamped;
                    dm_rem_d = dm_clamped;
                    im_ptr_d = '0;
                    dm_ptr_d = '0;
                    if (im_clamped != '0)      state_d = S_LOAD_IM;
                    else if (dm_clamped != '0) state_d = S_LOAD_DM;
                    else                       state_d = S_FLUSH;
                end
            end
            S_LOAD_IM: begin
                if (accept) begin
                    im_wr_d   = 1'b1;
                    im_addr_d = im_ptr_q;
                    im_data_d = in_data;
                    im_rem_d  = im_rem_q - CW'(1);
                    if (im_rem_q == CW'(1)) begin
                        state_d = (dm_rem_q != '0) ? S_LOAD_DM : S_FLUSH;
                    end else begin
                        im_ptr_d = im_ptr_q + ADDRESS_WIDTH'(1);
                    end
                end
            end
            S_LOAD_DM: begin
                if (accept) begin
                    dm_wr_d   = 1'b1;
                    dm_addr_d = dm_ptr_q;
                    dm_data_d = in_data;
                    dm_rem_d  = dm_rem_q - CW'(1);
                    if (dm_rem_q == CW'(1)) begin
                        state_d = S_FLUSH;
                    end else begin
                        dm_ptr_d = dm_ptr_q + ADDRESS_WIDTH'(1);
                    end
                end
            end
            // The final registered write lands in memory during this cycle.
            S_FLUSH: state_d = S_RUN;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            im_rem_q  <= '0;
            dm_rem_q  <= '0;
            im_ptr_q  <= '0;
            dm_ptr_q  <= '0;
            im_wr_q   <= 1'b0;
            dm_wr_q   <= 1'b0;
            im_addr_q <= '0;
            dm_addr_q <= '0;
            im_data_q <= '0;
            dm_data_q <= '0;
        end else begin
            state_q   <= state_d;
            im_rem_q  <= im_rem_d;
            dm_rem_q  <= dm_rem_d;
            im_ptr_q  <= im_ptr_d;
            dm_ptr_q  <= dm_ptr_d;
            im_wr_q   <= im_wr_d;
            dm_wr_q   <= dm_wr_d;
            im_addr_q <= im_addr_d;
            dm_addr_q <= dm_addr_d;
            im_data_q <= im_data_d;
            dm_data_q <= dm_data_d;
        end
    end

    assign loading   = (state_q != S_RUN);
    assign cpu_rst_n = (state_q == S_RUN);
    assign done      = (state_q == S_RUN);
    assign busy      = (state_q == S_LOAD_IM) || (state_q == S_LOAD_DM) || (state_q == S_FLUSH);

    assign im_cen_load    = ~im_wr_q;
    assign im_wen_load    = ~im_wr_q;
    assign im_oen_load    = 1'b1;
    assign im_addr_load   = im_addr_q;
    assign im_datain_load = im_data_q;
    assign dm_cen_load    = ~dm_wr_q;
    assign dm_wen_load    = ~dm_wr_q;
    assign dm_oen_load    = 1'b1;
    assign dm_addr_load   = dm_addr_q;
    assign dm_datain_load = dm_data_q;

endmodule
